// File: rtl/arm_pkg.sv
// Shared types for the ARM core issue logic.
// Register index and scoreboard counter definitions.
package arm_pkg;

  localparam int NUM_REGS = 16;
  localparam int SB_CNT_W = 2;

  typedef logic [3:0]          reg_idx_t;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down in-flight write counter for one register.
// Simultaneous inc and dec cancel; clr wins over both.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             one,
  output logic             err
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             max;

  assign max  = &cnt_q;
  assign zero = (cnt_q == '0);
  assign one  = (cnt_q == CNT_W'(1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (max) err   = 1'b1;
      else     cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (zero) err   = 1'b1;
      else      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: tracks in-flight destination
// writes from ID to WB and produces the ID stall decision.
module reg_scoreboard
  import arm_pkg::*;
#(
  parameter int NUM_REGS = arm_pkg::NUM_REGS,
  parameter int CNT_W    = arm_pkg::SB_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  reg_idx_t            issue_dest,
  input  reg_idx_t            src1_ID,
  input  reg_idx_t            src2_ID,
  input  logic                two_src_ID,
  input  logic                move,
  input  logic                wb_valid,
  input  reg_idx_t            wb_dest,
  input  logic                flush_all,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pending,
  output logic                busy,
  output logic                sb_err
);

  logic                issue_ev;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] zero;
  logic [NUM_REGS-1:0] one;
  logic [NUM_REGS-1:0] err;
  logic [NUM_REGS-1:0] live;
  logic                err_q;
  logic                err_d;

  // A stalled instruction never issues.
  assign issue_ev = issue_valid & issue_wb_en & ~hazard;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    localparam reg_idx_t IDX = reg_idx_t'(g);
    logic [CNT_W-1:0] cnt_unused;

    assign inc[g] = issue_ev & (issue_dest == IDX);
    assign dec[g] = wb_valid & (wb_dest == IDX);

    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (inc[g]),
      .dec  (dec[g]),
      .clr  (flush_all),
      .cnt  (cnt_unused),
      .zero (zero[g]),
      .one  (one[g]),
      .err  (err[g])
    );

    // Last write retiring now is already visible through the RF.
    assign live[g] = ~zero[g] & ~(one[g] & dec[g]);
  end

  always_comb begin
    hazard = 1'b0;
    if (!move) begin
      hazard = live[src1_ID] | (two_src_ID & live[src2_ID]);
    end
  end

  assign pending = ~zero;
  assign busy    = |pending;

  always_comb begin
    err_d = err_q | (|err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign sb_err = err_q;

endmodule
